// File: rtl/multi_digit_counter_display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_digit_counter_display_pkg                                      |
// | Active-low 7-segment glyph encoding and shared defaults.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package multi_digit_counter_display_pkg;

   localparam int DEFAULT_FPGA_CLK = 50_000_000;

   // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
   typedef enum logic [6:0] {
      SEG_ZERO  = 7'h40, SEG_ONE   = 7'h79, SEG_TWO   = 7'h24, SEG_THREE = 7'h30,
      SEG_FOUR  = 7'h19, SEG_FIVE  = 7'h12, SEG_SIX   = 7'h02, SEG_SEVEN = 7'h78,
      SEG_EIGHT = 7'h00, SEG_NINE  = 7'h10, SEG_A     = 7'h08, SEG_B     = 7'h03,
      SEG_C     = 7'h46, SEG_D     = 7'h21, SEG_E     = 7'h06, SEG_F     = 7'h0E,
      SEG_BLANK = 7'h7F
   } seg_t;

   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t s;
      s = SEG_BLANK;
      case (nib)
         4'h0: s = SEG_ZERO;
         4'h1: s = SEG_ONE;
         4'h2: s = SEG_TWO;
         4'h3: s = SEG_THREE;
         4'h4: s = SEG_FOUR;
         4'h5: s = SEG_FIVE;
         4'h6: s = SEG_SIX;
         4'h7: s = SEG_SEVEN;
         4'h8: s = SEG_EIGHT;
         4'h9: s = SEG_NINE;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         4'hF: s = SEG_F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_digit_counter_display_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen                                                             |
// | One-cycle enable pulse every FPGA_CLK/TARGET_FREQ clock cycles.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tick_gen
   import multi_digit_counter_display_pkg::*;
#(
   parameter int FPGA_CLK    = DEFAULT_FPGA_CLK,
   parameter int TARGET_FREQ = 1
) (
   input  logic FPGA_clk,
   input  logic rst,
   output logic tick
);

   localparam int c_DIV = (TARGET_FREQ > 0) ? (FPGA_CLK / TARGET_FREQ) : 0;
   localparam int c_CW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;

   if (c_DIV < 1) begin : g_bad_ratio
      $error("tick_gen: FPGA_CLK/TARGET_FREQ must be at least 1");
   end

   logic [c_CW-1:0] r_cnt;

   always_ff @(posedge FPGA_clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         tick  <= 1'b0;
      end else if (r_cnt == c_CW'(c_DIV - 1)) begin
         r_cnt <= '0;
         tick  <= 1'b1;
      end else begin
         r_cnt <= r_cnt + c_CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/multi_digit_counter_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_digit_counter_display                                          |
// | Multi-digit BCD/hex up/down counter with multiplexed 7-seg output.   |
// | Optional macro LEADING_ZERO_BLANK_EN blanks leading zero positions.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multi_digit_counter_display
   import multi_digit_counter_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DEC_MODE   = 1,
   parameter int FPGA_CLK   = DEFAULT_FPGA_CLK,
   parameter int COUNT_FREQ = 2,
   parameter int SCAN_FREQ  = 1000
) (
   input  logic                  FPGA_clk,
   input  logic                  rst,
   input  logic                  count_en,
   input  logic                  up_dn,
   input  logic                  clear,
   output logic [7:0]            LED_7Seg,
   output logic [NUM_DIGITS-1:0] EN_LED_7Seg,
   output logic                  wrap
);

   localparam logic [3:0] c_DIGIT_MAX = (DEC_MODE != 0) ? 4'd9 : 4'd15;
   localparam int         c_IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("multi_digit_counter_display: NUM_DIGITS must be 1..8");
   end

   logic w_count_tick;
   logic w_scan_tick;

   tick_gen #(.FPGA_CLK(FPGA_CLK), .TARGET_FREQ(COUNT_FREQ)) u_count_tick (
      .FPGA_clk (FPGA_clk),
      .rst      (rst),
      .tick     (w_count_tick)
   );

   tick_gen #(.FPGA_CLK(FPGA_CLK), .TARGET_FREQ(SCAN_FREQ)) u_scan_tick (
      .FPGA_clk (FPGA_clk),
      .rst      (rst),
      .tick     (w_scan_tick)
   );

   logic [3:0] r_digit [NUM_DIGITS];
   logic [3:0] w_next  [NUM_DIGITS];
   logic       w_carry;

   // Ripple the carry/borrow upward; a surviving carry out of the top digit is a wrap.
   always_comb begin
      w_carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_next[i] = r_digit[i];
         if (w_carry) begin
            if (up_dn)
               w_next[i] = (r_digit[i] == c_DIGIT_MAX) ? 4'd0 : r_digit[i] + 4'd1;
            else
               w_next[i] = (r_digit[i] == 4'd0) ? c_DIGIT_MAX : r_digit[i] - 4'd1;
         end
         w_carry = w_carry & (up_dn ? (r_digit[i] == c_DIGIT_MAX) : (r_digit[i] == 4'd0));
      end
   end

   always_ff @(posedge FPGA_clk or posedge rst) begin
      if (rst) begin
         r_digit <= '{default: 4'd0};
         wrap    <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clear) begin
            r_digit <= '{default: 4'd0};
         end else if (w_count_tick && count_en) begin
            r_digit <= w_next;
            wrap    <= w_carry;
         end
      end
   end

   logic [c_IW-1:0] r_idx;
   logic            r_scan_on;

   // The first scan tick after reset only arms the display at position 0.
   always_ff @(posedge FPGA_clk or posedge rst) begin
      if (rst) begin
         r_idx     <= '0;
         r_scan_on <= 1'b0;
      end else if (w_scan_tick) begin
         if (!r_scan_on)
            r_scan_on <= 1'b1;
         else if (r_idx == c_IW'(NUM_DIGITS - 1))
            r_idx <= '0;
         else
            r_idx <= r_idx + c_IW'(1);
      end
   end

   logic [NUM_DIGITS-1:0] w_blank;

`ifdef LEADING_ZERO_BLANK_EN
   logic w_upper_zero;

   always_comb begin
      w_blank      = '0;
      w_upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         w_upper_zero = w_upper_zero & (r_digit[i] == 4'd0);
         w_blank[i]   = w_upper_zero;
      end
   end
`else
   assign w_blank = '0;
`endif

   always_ff @(posedge FPGA_clk or posedge rst) begin
      if (rst) begin
         LED_7Seg    <= 8'hFF;
         EN_LED_7Seg <= '1;
      end else if (r_scan_on) begin
         EN_LED_7Seg   <= ~(NUM_DIGITS'(1) << r_idx);
         LED_7Seg[6:0] <= w_blank[r_idx] ? SEG_BLANK : hex_to_seg(r_digit[r_idx]);
         LED_7Seg[7]   <= ~((r_idx == '0) && !count_en);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_counter_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_digit_counter_display                                       |
// | Scoreboard bench: 2-digit BCD and 4-digit hex instances, shared ctl. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multi_digit_counter_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       count_en = 1'b0;
   logic       up_dn = 1'b1;
   logic       clear = 1'b0;
   logic [7:0] seg_a, seg_b;
   logic [1:0] en_a;
   logic [3:0] en_b;
   logic       wrap_a, wrap_b;

   always #5 clk = ~clk;

   multi_digit_counter_display #(
      .NUM_DIGITS(2), .DEC_MODE(1), .FPGA_CLK(100), .COUNT_FREQ(10), .SCAN_FREQ(50)
   ) u_dut_a (
      .FPGA_clk(clk), .rst(rst), .count_en(count_en), .up_dn(up_dn), .clear(clear),
      .LED_7Seg(seg_a), .EN_LED_7Seg(en_a), .wrap(wrap_a)
   );

   multi_digit_counter_display #(
      .NUM_DIGITS(4), .DEC_MODE(0), .FPGA_CLK(100), .COUNT_FREQ(10), .SCAN_FREQ(50)
   ) u_dut_b (
      .FPGA_clk(clk), .rst(rst), .count_en(count_en), .up_dn(up_dn), .clear(clear),
      .LED_7Seg(seg_b), .EN_LED_7Seg(en_b), .wrap(wrap_b)
   );

   // Active-high glyphs {g,f,e,d,c,b,a}; the display drives their complement.
   localparam logic [6:0] HI_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   localparam logic [3:0] EN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   typedef struct { int dut; int pos; logic [7:0] seg; } disp_t;
   typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

   disp_t dq[$];
   chk_t  cq[$];
   int    total = 0;
   int    bad = 0;
   int    val_a = 0;
   int    val_b = 0;
   int    wrap_cnt_a = 0;
   int    wrap_cnt_b = 0;

   function automatic logic [7:0] exp_seg(input int dut, input int pos);
      int         d;
      logic [6:0] g;
      if (dut == 0) d = ((pos == 0) ? val_a : val_a / 10) % 10;
      else          d = (val_b >> (4 * pos)) & 15;
      g = ~HI_GLYPH[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (pos > 0 && ((dut == 0) ? (val_a / 10) : (val_b >> (4 * pos))) == 0) g = 7'h7F;
`endif
      return {~((pos == 0) && !count_en), g};
   endfunction

   task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
      cq.push_back('{name, act, exp});
   endtask

   task automatic push_all();
      for (int p = 0; p < 2; p++) dq.push_back('{0, p, exp_seg(0, p)});
      for (int p = 0; p < 4; p++) dq.push_back('{1, p, exp_seg(1, p)});
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((dq.size() != 0 || cq.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (dq.size() != 0 || cq.size() != 0) post("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic apply_ticks(input int n, input bit up);
      @(negedge clk);
      up_dn    = up;
      count_en = 1'b1;
      repeat (10 * n) @(negedge clk);
      count_en = 1'b0;
      for (int k = 0; k < n; k++) begin
         val_a = up ? (val_a + 1) % 100 : (val_a + 99) % 100;
         val_b = up ? (val_b + 1) % 65536 : (val_b + 65535) % 65536;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      val_a = 0;
      val_b = 0;
      repeat (2) @(negedge clk);
   endtask

   // Monitor: consumes scoreboard entries whenever the DUT presents them.
   disp_t      cur;
   chk_t       ck;
   logic [7:0] en8, sg;
   int         wait_cyc = 0;
   logic       prev_wa = 1'b0, prev_wb = 1'b0;

   always @(negedge clk) begin
      while (cq.size() != 0) begin
         ck = cq.pop_front();
         total++;
         if (ck.act !== ck.exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", ck.name, ck.act, ck.exp);
         end
      end
      if (dq.size() != 0) begin
         cur = dq[0];
         en8 = (cur.dut == 0) ? {6'h3F, en_a} : {4'hF, en_b};
         sg  = (cur.dut == 0) ? seg_a : seg_b;
         if (en8[cur.pos] == 1'b0) begin
            total++;
            if (sg !== cur.seg || en8 !== ~(8'h01 << cur.pos)) begin
               bad++;
               $display("FAIL disp dut%0d pos%0d: seg=%h en=%b, want seg=%h en=%b",
                        cur.dut, cur.pos, sg, en8, cur.seg, ~(8'h01 << cur.pos));
            end
            void'(dq.pop_front());
            wait_cyc = 0;
         end else if (++wait_cyc > 100) begin
            total++;
            bad++;
            $display("FAIL disp_timeout dut%0d pos%0d: en=%b, want pos enabled", cur.dut, cur.pos, en8);
            void'(dq.pop_front());
            wait_cyc = 0;
         end
      end
      if (wrap_a) begin
         wrap_cnt_a++;
         total++;
         if (prev_wa) begin
            bad++;
            $display("FAIL wrap_a_width: got 2+ cycles, want 1");
         end
      end
      if (wrap_b) begin
         wrap_cnt_b++;
         total++;
         if (prev_wb) begin
            bad++;
            $display("FAIL wrap_b_width: got 2+ cycles, want 1");
         end
      end
      prev_wa = wrap_a;
      prev_wb = wrap_b;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] prev;
      bit         found;

      repeat (3) @(negedge clk);
      post("rst_seg_a", seg_a, 8'hFF);
      post("rst_en_a", en_a, 2'b11);
      post("rst_seg_b", seg_b, 8'hFF);
      post("rst_en_b", en_b, 4'b1111);
      post("rst_wrap", {wrap_a, wrap_b}, 2'b00);
      rst = 1'b0;

      prev  = en_b;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (en_b == 4'b1110 && prev != 4'b1110) found = 1'b1;
         else prev = en_b;
      end
      if (!found) post("en_start_timeout", 32'd0, 32'd1);
      for (int k = 0; k < 8; k++) begin
         post("en_seq", en_b, EN_PAT[k / 2]);
         @(negedge clk);
      end
      push_all();
      wait_drain();

      apply_ticks(99, 1'b1);
      push_all();
      post("wrap_a_99", wrap_cnt_a, 0);
      wait_drain();

      apply_ticks(1, 1'b1);
      push_all();
      post("wrap_a_up", wrap_cnt_a, 1);
      post("wrap_b_up", wrap_cnt_b, 0);
      wait_drain();

      do_clear();
      post("wrap_a_clear", wrap_cnt_a, 1);
      apply_ticks(1, 1'b0);
      push_all();
      post("wrap_a_down", wrap_cnt_a, 2);
      post("wrap_b_down", wrap_cnt_b, 1);
      wait_drain();

      do_clear();
      apply_ticks(42, 1'b1);
      push_all();
      wait_drain();

      // clear held across a count tick with count_en=1: clear wins, no wrap
      @(negedge clk);
      clear    = 1'b1;
      count_en = 1'b1;
      val_a    = 0;
      val_b    = 0;
      repeat (2) @(negedge clk);
      dq.push_back('{0, 0, exp_seg(0, 0)});
      wait_drain();
      repeat (12) @(negedge clk);
      clear    = 1'b0;
      count_en = 1'b0;
      repeat (2) @(negedge clk);
      push_all();
      post("wrap_a_clrtick", wrap_cnt_a, 2);
      post("wrap_b_clrtick", wrap_cnt_b, 1);
      wait_drain();

      apply_ticks(7, 1'b1);
      push_all();
      wait_drain();

      do_clear();
      apply_ticks(291, 1'b1);
      push_all();
      post("wrap_a_291", wrap_cnt_a, 4);
      post("wrap_b_291", wrap_cnt_b, 1);
      wait_drain();

      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      post("async_seg_a", seg_a, 8'hFF);
      post("async_en_a", en_a, 2'b11);
      post("async_seg_b", seg_b, 8'hFF);
      post("async_en_b", en_b, 4'b1111);
      post("async_wrap", {wrap_a, wrap_b}, 2'b00);
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      val_a = 0;
      val_b = 0;
      push_all();
      wait_drain();

      apply_ticks(1, 1'b1);
      push_all();
      post("wrap_a_end", wrap_cnt_a, 4);
      wait_drain();

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_digit_counter_display.md
MULTI_DIGIT_COUNTER_DISPLAY -- requirements
Module: multi_digit_counter_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of counter digits and display positions; legal range 1..8.
REQ-002 Parameter DEC_MODE, default 1: 1 = each digit counts 0..9 (BCD); 0 = each digit counts 0..F (hex).
REQ-003 Parameter FPGA_CLK, default 50_000_000: input clock frequency in Hz.
REQ-004 Parameter COUNT_FREQ, default 2: count ticks per second.
REQ-005 Parameter SCAN_FREQ, default 1000: digit-slot advances per second.
REQ-006 FPGA_clk  in  1  single system clock; all logic on its rising edge; no derived clocks.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 count_en  in  1  1 = count ticks are applied; 0 = hold value.
REQ-009 up_dn  in  1  1 = count up; 0 = count down.
REQ-010 clear  in  1  synchronous clear of all digits to 0.
REQ-011 LED_7Seg  out  8  active-low segments; bit 7 = dp, bits 6:0 = {g,f,e,d,c,b,a}.
REQ-012 EN_LED_7Seg  out  NUM_DIGITS  active-low digit enables; bit i drives display position i (0 = least significant).
REQ-013 wrap  out  1  one-cycle pulse on counter wrap-around.

Function
REQ-014 An internal count tick SHALL be a one-cycle pulse every FPGA_CLK/COUNT_FREQ cycles; a scan tick SHALL be a one-cycle pulse every FPGA_CLK/SCAN_FREQ cycles.
REQ-015 Either divide ratio below 1, or NUM_DIGITS outside 1..8, SHALL be an elaboration error.
REQ-016 Counter update cycle: clear=1, or count tick with count_en=1; clear SHALL take priority and SHALL NOT pulse wrap.
REQ-017 Count up: digit 0 increments; digit i increments only when all lower digits are at max (9 or F); a digit at max SHALL roll to 0.
REQ-018 Count down: digit 0 decrements; digit i decrements only when all lower digits are 0; a digit at 0 SHALL roll to max.
REQ-019 Up from all-max SHALL give all-zero, down from all-zero SHALL give all-max; wrap SHALL be 1 in the cycle after that update, 0 otherwise.
REQ-020 Changing up_dn or count_en between ticks SHALL take effect at the next tick only.
REQ-021 A scan index SHALL advance 0..NUM_DIGITS-1 on each scan tick and wrap to 0.
REQ-022 LED_7Seg and EN_LED_7Seg SHALL be registered together; one cycle after the index changes, exactly one EN bit (the index) SHALL be 0 and LED_7Seg[6:0] SHALL encode that digit's current value.
REQ-023 In DEC_MODE=1 only glyphs 0..9 SHALL appear; DEC_MODE=0 SHALL use glyphs 0..F.
REQ-024 dp (LED_7Seg[7]) SHALL be 0 (lit) only on position 0 while count_en=0; otherwise 1.
REQ-025 A counter change SHALL appear on the display no later than the next time that position is scanned.

Reset
REQ-026 While rst=1: all digits 0, scan index 0, LED_7Seg=8'hFF, EN_LED_7Seg all 1, wrap=0, both tick counters 0.
REQ-027 After rst falls, position 0 SHALL be enabled one cycle after the first scan tick; a reset mid-count SHALL discard the value with no wrap pulse.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: positions above the most significant nonzero digit SHALL show blank (LED_7Seg[6:0]=7'h7F) and position 0 SHALL always be shown; undefined: every position shows its digit, leading zeros included.

Structure
REQ-029 A shared package SHALL hold the active-low 7-segment glyph enum (0..F plus BLANK) and the default FPGA_CLK constant.
REQ-030 One sub-module, tick_gen (parameters FPGA_CLK and TARGET_FREQ; output a one-cycle enable pulse), SHALL be instantiated twice.

Verification
REQ-031 FPGA_CLK=100, COUNT_FREQ=10, SCAN_FREQ=50, NUM_DIGITS=2, DEC_MODE=1, up: 99 ticks -> value 99; next tick -> 00 with wrap high one cycle.
REQ-032 Same configuration, down from 00: one tick -> 99 with wrap pulse; DEC_MODE=0 -> FF.
REQ-033 clear and count tick in the same cycle at value 42 -> value 00 and wrap stays 0.
REQ-034 NUM_DIGITS=4: EN_LED_7Seg cycles 1110,1101,1011,0111 every 2 cycles; segments match the digit at each position; count_en=0 -> dp lit only at position 0.
REQ-035 LEADING_ZERO_BLANK_EN defined, value 0007 -> positions 3..1 show 7'h7F and position 0 shows SEVEN; value 0000 -> position 0 shows ZERO.
REQ-036 rst asserted mid-scan at value 0123 -> outputs at reset values immediately (asynchronously); after release the count restarts at 0000.
